// File: rtl/cluster_pkg.sv
// Shared definitions for the cluster step sequencer: default widths,
// sequencer state encoding and the cl_in packing order.
package cluster_pkg;

  localparam int IN_W_DEFAULT  = 1894;
  localparam int ST_W_DEFAULT  = 1024;
  localparam int CNT_W_DEFAULT = 32;

  // State bits occupy the least significant end of the cluster input
  // vector; external inputs sit directly above them.
  localparam int CL_IN_STATE_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/cluster_step_sequencer_step_counter.sv
// Step bookkeeping for a run: remaining steps counting down, completed
// steps counting up, and a flag marking the final update of a run.
module step_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_steps,
  input  logic             step,
  output logic [CNT_W-1:0] rem_q,
  output logic [CNT_W-1:0] done_q,
  output logic             last
);

  // Load starts a fresh run; each step moves one count from rem to done,
  // saturating so neither counter can wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      done_q <= '0;
    end else if (load) begin
      rem_q  <= load_steps;
      done_q <= '0;
    end else if (step) begin
      if (rem_q != '0) begin
        rem_q <= rem_q - CNT_W'(1);
      end
      if (done_q != '1) begin
        done_q <= done_q + CNT_W'(1);
      end
    end
  end

  // The step taken while exactly one remains is the last of the run.
  always_comb begin
    last = (rem_q == CNT_W'(1));
  end

endmodule

// File: rtl/cluster_step_sequencer.sv
// Sequential wrapper around the combinational cluster modules: holds the
// architectural state, presents {ext, state} to the clusters, captures
// their outputs once per cycle for a commanded number of steps and hands
// the final state back over a valid/ready handshake.
module cluster_step_sequencer
  import cluster_pkg::*;
#(
  parameter int IN_W  = IN_W_DEFAULT,
  parameter int ST_W  = ST_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [ST_W-1:0]      load_state,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CNT_W-1:0]     cmd_steps,
  input  logic [IN_W-ST_W-1:0] cmd_ext,
  input  logic                 abort,
  output logic [IN_W-1:0]      cl_in,
  input  logic [ST_W-1:0]      cl_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ST_W-1:0]      res_state,
  output logic [CNT_W-1:0]     res_steps,
  output logic                 busy
);

  localparam int EXT_W   = IN_W - ST_W;
  localparam int EXT_LSB = CL_IN_STATE_LSB + ST_W;

  seq_state_e seq_q;
  seq_state_e seq_d;

  logic [ST_W-1:0]  state_q;
  logic [EXT_W-1:0] ext_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] done_q;
  logic             last_step;

  logic load_fire;
  logic cmd_fire;
  logic step_en;

  step_counter #(
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cmd_fire),
    .load_steps (cmd_steps),
    .step       (step_en),
    .rem_q      (rem_q),
    .done_q     (done_q),
    .last       (last_step)
  );

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q <= IDLE;
    end else begin
      seq_q <= seq_d;
    end
  end

  // Next-state, handshake and step-enable decode; abort pre-empts the step.
  always_comb begin
    seq_d      = seq_q;
    load_ready = 1'b0;
    cmd_ready  = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b0;
    step_en    = 1'b0;
    load_fire  = 1'b0;
    cmd_fire   = 1'b0;
    unique case (seq_q)
      IDLE: begin
        load_ready = 1'b1;
        cmd_ready  = 1'b1;
        load_fire  = load_valid;
        cmd_fire   = cmd_valid;
        if (cmd_valid) begin
          seq_d = (cmd_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          seq_d = DONE;
        end else begin
          step_en = 1'b1;
          if (last_step) begin
            seq_d = DONE;
          end
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          seq_d = IDLE;
        end
      end
      default: begin
        seq_d = IDLE;
      end
    endcase
  end

  // Architectural state: a load wins in IDLE, a step captures cluster outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else if (load_fire) begin
      state_q <= load_state;
    end else if (step_en) begin
      state_q <= cl_out;
    end
  end

  // External inputs are latched with the command and held for the whole run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= '0;
    end else if (cmd_fire) begin
      ext_q <= cmd_ext;
    end
  end

  assign cl_in[CL_IN_STATE_LSB +: ST_W] = state_q;
  assign cl_in[EXT_LSB +: EXT_W]        = ext_q;

  // state_q and done_q only change in IDLE/RUN, so they are stable in DONE.
  assign res_state = state_q;
  assign res_steps = done_q;

endmodule

// File: tb/tb_cluster_step_sequencer.sv
// Directed bench for cluster_step_sequencer using an increment-by-one
// cluster model, so after N steps from state s the result is s+N.
module tb_cluster_step_sequencer;

  localparam int IN_W  = 1894;
  localparam int ST_W  = 1024;
  localparam int CNT_W = 32;
  localparam int EXT_W = IN_W - ST_W;

  logic              clk;
  logic              rst_n;
  logic              load_valid;
  logic              load_ready;
  logic [ST_W-1:0]   load_state;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_steps;
  logic [EXT_W-1:0]  cmd_ext;
  logic              abort;
  logic [IN_W-1:0]   cl_in;
  logic [ST_W-1:0]   cl_out;
  logic              res_valid;
  logic              res_ready;
  logic [ST_W-1:0]   res_state;
  logic [CNT_W-1:0]  res_steps;
  logic              busy;

  int check_count;
  int error_count;
  int busy_cycles;

  cluster_step_sequencer #(
    .IN_W  (IN_W),
    .ST_W  (ST_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_state (load_state),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_ext    (cmd_ext),
    .abort      (abort),
    .cl_in      (cl_in),
    .cl_out     (cl_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_state  (res_state),
    .res_steps  (res_steps),
    .busy       (busy)
  );

  // Cluster model: next state is the current state plus one.
  assign cl_out = cl_in[ST_W-1:0] + ST_W'(1);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [ST_W-1:0] observed,
                             input logic [ST_W-1:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ld_v, input logic [ST_W-1:0] ld_s,
                               input logic c_v, input logic [CNT_W-1:0] steps,
                               input logic [EXT_W-1:0] ext);
    load_valid = ld_v;
    load_state = ld_s;
    cmd_valid  = c_v;
    cmd_steps  = steps;
    cmd_ext    = ext;
    stepClock();
    load_valid = 1'b0;
    cmd_valid  = 1'b0;
  endtask

  task automatic countBusy(input int bound);
    busy_cycles = 0;
    while (busy && busy_cycles < bound) begin
      busy_cycles++;
      stepClock();
    end
  endtask

  task automatic releaseResult();
    res_ready = 1'b1;
    stepClock();
    res_ready = 1'b0;
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_state = '0;
    cmd_valid  = 1'b0;
    cmd_steps  = '0;
    cmd_ext    = '0;
    abort      = 1'b0;
    res_ready  = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_res_valid", ST_W'(res_valid), ST_W'(0));
    checkOutput("rst_busy", ST_W'(busy), ST_W'(0));
    checkOutput("rst_load_ready", ST_W'(load_ready), ST_W'(1));
    checkOutput("rst_cmd_ready", ST_W'(cmd_ready), ST_W'(1));
    checkOutput("rst_cl_in_state", cl_in[ST_W-1:0], ST_W'(0));
    checkOutput("rst_cl_in_ext", ST_W'(cl_in[IN_W-1:ST_W]), ST_W'(0));
    checkOutput("rst_res_state", res_state, ST_W'(0));
    checkOutput("rst_res_steps", ST_W'(res_steps), ST_W'(0));
    rst_n = 1'b1;

    // Load 0x5A then a zero-step command: result next cycle, state untouched
    applyStimulus(1'b1, ST_W'(32'h5A), 1'b0, '0, '0);
    applyStimulus(1'b0, '0, 1'b1, 32'd0, '0);
    checkOutput("n0_res_valid", ST_W'(res_valid), ST_W'(1));
    checkOutput("n0_busy", ST_W'(busy), ST_W'(0));
    checkOutput("n0_res_state", res_state, ST_W'(32'h5A));
    checkOutput("n0_res_steps", ST_W'(res_steps), ST_W'(0));
    releaseResult();
    checkOutput("n0_back_idle", ST_W'(cmd_ready), ST_W'(1));

    // Load 0, ten steps: busy for exactly ten cycles
    applyStimulus(1'b1, '0, 1'b0, '0, '0);
    applyStimulus(1'b0, '0, 1'b1, 32'd10, '0);
    countBusy(200);
    checkOutput("n10_busy_cycles", ST_W'(busy_cycles), ST_W'(10));
    checkOutput("n10_res_valid", ST_W'(res_valid), ST_W'(1));
    checkOutput("n10_res_state", res_state, ST_W'(10));
    checkOutput("n10_res_steps", ST_W'(res_steps), ST_W'(10));
    releaseResult();

    // Abort in the fourth RUN cycle of a 100-step run
    applyStimulus(1'b1, '0, 1'b0, '0, '0);
    applyStimulus(1'b0, '0, 1'b1, 32'd100, '0);
    stepClock();
    stepClock();
    stepClock();
    checkOutput("abort_busy", ST_W'(busy), ST_W'(1));
    abort = 1'b1;
    stepClock();
    abort = 1'b0;
    checkOutput("abort_res_valid", ST_W'(res_valid), ST_W'(1));
    checkOutput("abort_res_steps", ST_W'(res_steps), ST_W'(3));
    checkOutput("abort_res_state", res_state, ST_W'(3));
    releaseResult();
    checkOutput("abort_idle_cmd_ready", ST_W'(cmd_ready), ST_W'(1));
    checkOutput("abort_idle_busy", ST_W'(busy), ST_W'(0));

    // Load 7 and two steps together, ext 0x3, res_ready already high
    res_ready = 1'b1;
    applyStimulus(1'b1, ST_W'(7), 1'b1, 32'd2, EXT_W'(3));
    checkOutput("same_run1_busy", ST_W'(busy), ST_W'(1));
    checkOutput("same_run1_ext", ST_W'(cl_in[IN_W-1:ST_W]), ST_W'(3));
    checkOutput("same_run1_state", cl_in[ST_W-1:0], ST_W'(7));
    stepClock();
    checkOutput("same_run2_ext", ST_W'(cl_in[IN_W-1:ST_W]), ST_W'(3));
    stepClock();
    checkOutput("same_done_valid", ST_W'(res_valid), ST_W'(1));
    checkOutput("same_done_state", res_state, ST_W'(9));
    checkOutput("same_done_steps", ST_W'(res_steps), ST_W'(2));
    stepClock();
    res_ready = 1'b0;
    checkOutput("same_idle_valid", ST_W'(res_valid), ST_W'(0));
    checkOutput("same_idle_cmd_ready", ST_W'(cmd_ready), ST_W'(1));

    // Result held for 20 cycles with loads and commands refused
    applyStimulus(1'b1, ST_W'(32'h10), 1'b0, '0, '0);
    applyStimulus(1'b0, '0, 1'b1, 32'd5, '0);
    countBusy(200);
    checkOutput("hold_busy_cycles", ST_W'(busy_cycles), ST_W'(5));
    load_valid = 1'b1;
    load_state = ST_W'(32'hDEAD);
    cmd_valid  = 1'b1;
    cmd_steps  = 32'd1;
    for (int i = 0; i < 20; i++) begin
      checkOutput("hold_res_valid", ST_W'(res_valid), ST_W'(1));
      checkOutput("hold_res_state", res_state, ST_W'(32'h15));
      checkOutput("hold_load_ready", ST_W'(load_ready), ST_W'(0));
      checkOutput("hold_cmd_ready", ST_W'(cmd_ready), ST_W'(0));
      stepClock();
    end
    load_valid = 1'b0;
    cmd_valid  = 1'b0;
    checkOutput("hold_res_steps", ST_W'(res_steps), ST_W'(5));
    releaseResult();
    applyStimulus(1'b0, '0, 1'b1, 32'd3, '0);
    countBusy(200);
    checkOutput("chain_res_state", res_state, ST_W'(32'h18));
    checkOutput("chain_res_steps", ST_W'(res_steps), ST_W'(3));
    releaseResult();

    // Asynchronous reset in RUN cycle 5 of a 50-step run
    applyStimulus(1'b0, '0, 1'b1, 32'd50, EXT_W'(5));
    stepClock();
    stepClock();
    stepClock();
    stepClock();
    checkOutput("arst_pre_busy", ST_W'(busy), ST_W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", ST_W'(busy), ST_W'(0));
    checkOutput("arst_res_valid", ST_W'(res_valid), ST_W'(0));
    checkOutput("arst_load_ready", ST_W'(load_ready), ST_W'(1));
    checkOutput("arst_cmd_ready", ST_W'(cmd_ready), ST_W'(1));
    checkOutput("arst_cl_in_state", cl_in[ST_W-1:0], ST_W'(0));
    checkOutput("arst_cl_in_ext", ST_W'(cl_in[IN_W-1:ST_W]), ST_W'(0));
    checkOutput("arst_res_state", res_state, ST_W'(0));
    checkOutput("arst_res_steps", ST_W'(res_steps), ST_W'(0));
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 32'd4, '0);
    countBusy(200);
    checkOutput("fresh_busy_cycles", ST_W'(busy_cycles), ST_W'(4));
    checkOutput("fresh_res_state", res_state, ST_W'(4));
    checkOutput("fresh_res_steps", ST_W'(res_steps), ST_W'(4));
    releaseResult();

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
